// File: rtl/tla_pkg.sv
// -----------------------------------------------------------------------------
// tla_pkg
// Shared definitions for the sample merge/pack capture block:
//   - default parameter values (sample width, lanes per word, FIFO depth,
//     capture-length field width)
//   - capture FSM state encoding
// -----------------------------------------------------------------------------
package tla_pkg;

    localparam int TLA_ADC_W_DEF = 14;   // ADC sample width in bits
    localparam int TLA_LANES_DEF = 4;    // samples per merge word
    localparam int TLA_DEPTH_DEF = 16;   // output FIFO depth in words
    localparam int TLA_LEN_W_DEF = 32;   // capture-length field width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_DRAIN = 2'd2
    } tla_state_e;

endpackage

// File: rtl/tla_sync_fifo.sv
// -----------------------------------------------------------------------------
// tla_sync_fifo
// Single-clock show-ahead FIFO. The word at the read pointer is presented on
// o_data whenever the FIFO is not empty; i_pop consumes it.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_flush  : empties the FIFO; wins over push and pop in the same cycle
//   i_push   : write i_data (ignored when full unless a pop happens too)
//   i_data   : write data
//   i_pop    : consume the presented word (ignored when empty)
//   o_data   : presented word, forced to zero while empty
//   o_full   : FIFO holds DEPTH words
//   o_empty  : FIFO holds no words
//   o_count  : number of stored words
// -----------------------------------------------------------------------------
module tla_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_rd_en;
    logic w_wr_en;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;

    // A pop frees the slot in the same cycle, so a full FIFO can still accept
    // a push when it is also being read.
    assign w_rd_en = i_pop && !o_empty && !i_flush;
    assign w_wr_en = i_push && (!o_full || w_rd_en) && !i_flush;

    // Zero while empty keeps the output deterministic (RAM content is not reset).
    // The presented entry cannot be overwritten while it is held: a write to
    // the read slot is only possible when full, and then only alongside a pop.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tla_merge_pack.sv
// -----------------------------------------------------------------------------
// tla_merge_pack
// Captures a programmed number of merge words from an ADC sample stream.
// LANES consecutive valid samples are packed into one word (lane 0 in the
// LSBs) together with the OR of their overrange flags, and queued in a
// show-ahead FIFO towards a valid/ready consumer.
//
// Ports
//   Gc_clk125     : clock, rising edge
//   Gc_rst        : asynchronous active-low reset
//   Gc_adc_data   : sample data
//   Gc_adc_of     : sample overrange flag
//   Gc_adc_datv   : sample valid
//   Gc_cap_trig   : capture start pulse (IDLE only)
//   Gc_cap_plus   : number of words to capture, sampled with the trigger
//   Gc_cap_abort  : cancel capture, flush FIFO
//   Gc_merge_data : packed word
//   Gc_merge_of   : overrange OR of the presented word
//   Gc_merge_datv : word valid
//   Gc_merge_datr : consumer ready
//   Gc_capr_rdy   : high while IDLE
//   Gc_cap_cmpt   : one-cycle pulse when a capture completes
//   Gc_cap_drop   : sticky, a completed word was lost to a full FIFO
// -----------------------------------------------------------------------------
module tla_merge_pack
    import tla_pkg::*;
#(
    parameter int ADC0_0 = TLA_ADC_W_DEF,
    parameter int LANES  = TLA_LANES_DEF,
    parameter int DEPTH  = TLA_DEPTH_DEF,
    parameter int LDD0_0 = TLA_LEN_W_DEF
) (
    input  logic                     Gc_clk125,
    input  logic                     Gc_rst,
    input  logic [ADC0_0-1:0]        Gc_adc_data,
    input  logic                     Gc_adc_of,
    input  logic                     Gc_adc_datv,
    input  logic                     Gc_cap_trig,
    input  logic [LDD0_0-1:0]        Gc_cap_plus,
    input  logic                     Gc_cap_abort,
    output logic [LANES*ADC0_0-1:0]  Gc_merge_data,
    output logic                     Gc_merge_of,
    output logic                     Gc_merge_datv,
    input  logic                     Gc_merge_datr,
    output logic                     Gc_capr_rdy,
    output logic                     Gc_cap_cmpt,
    output logic                     Gc_cap_drop
);

    localparam int WORD_W = LANES * ADC0_0;
    localparam int LIDX_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

    tla_state_e          r_state;
    logic [LIDX_W-1:0]   r_lane_idx;
    logic [LDD0_0-1:0]   r_word_cnt;
    logic                r_cmpt;
    logic                r_drop;

    logic [WORD_W-1:0]   w_word;
    logic [LANES-2:0]    w_lane_of;
    logic                w_word_of;
    logic                w_take;
    logic                w_word_done;
    logic                w_pop;
    logic                w_drop;
    logic                w_drain_done;

    logic [WORD_W:0]     w_fifo_q;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_count;

    // Abort blocks sample intake in the cycle it is asserted.
    assign w_take      = (r_state == ST_PACK) && Gc_adc_datv && !Gc_cap_abort;
    assign w_word_done = w_take && (r_lane_idx == LAST_LANE);
    assign w_pop       = Gc_merge_datr && !w_fifo_empty;
    assign w_drop      = w_word_done && w_fifo_full && !w_pop;

    // The FIFO empties this cycle either because it is already empty or the
    // last word is being accepted now (nothing is pushed while draining).
    assign w_drain_done = (r_state == ST_DRAIN) &&
                          (w_fifo_empty || ((w_fifo_count == CNT_W'(1)) && w_pop));

    // Lanes 0..LANES-2 are held in registers; the last lane is taken straight
    // from the input so the word is pushed in the same cycle it completes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
            logic [ADC0_0-1:0] r_data;
            logic              r_of;

            always_ff @(posedge Gc_clk125 or negedge Gc_rst) begin
                if (!Gc_rst) begin
                    r_data <= '0;
                    r_of   <= 1'b0;
                end else if (w_take && (r_lane_idx == LIDX_W'(gi))) begin
                    r_data <= Gc_adc_data;
                    r_of   <= Gc_adc_of;
                end
            end

            assign w_word[gi*ADC0_0 +: ADC0_0] = r_data;
            assign w_lane_of[gi]               = r_of;
        end
    endgenerate

    assign w_word[(LANES-1)*ADC0_0 +: ADC0_0] = Gc_adc_data;
    assign w_word_of = (|w_lane_of) | Gc_adc_of;

    tla_sync_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (Gc_clk125),
        .i_rst_n (Gc_rst),
        .i_flush (Gc_cap_abort),
        .i_push  (w_word_done),
        .i_data  ({w_word_of, w_word}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge Gc_clk125 or negedge Gc_rst) begin
        if (!Gc_rst) begin
            r_state    <= ST_IDLE;
            r_lane_idx <= '0;
            r_word_cnt <= '0;
            r_cmpt     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_cmpt <= 1'b0;
            if (Gc_cap_abort) begin
                // Abort wins over everything, including a completion pulse.
                r_state    <= ST_IDLE;
                r_lane_idx <= '0;
                r_word_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (Gc_cap_trig) begin
                            if (Gc_cap_plus != '0) begin
                                r_word_cnt <= Gc_cap_plus;
                                r_drop     <= 1'b0;
                                r_lane_idx <= '0;
                                r_state    <= ST_PACK;
                            end else begin
                                r_cmpt <= 1'b1;
                            end
                        end
                    end
                    ST_PACK: begin
                        if (w_take) begin
                            if (w_word_done) begin
                                r_lane_idx <= '0;
                                r_word_cnt <= r_word_cnt - LDD0_0'(1);
                                if (w_drop) begin
                                    r_drop <= 1'b1;
                                end
                                if (r_word_cnt == LDD0_0'(1)) begin
                                    r_state <= ST_DRAIN;
                                end
                            end else begin
                                r_lane_idx <= r_lane_idx + LIDX_W'(1);
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_drain_done) begin
                            r_cmpt  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Gc_merge_data = w_fifo_q[WORD_W-1:0];
    assign Gc_merge_of   = w_fifo_q[WORD_W];
    assign Gc_merge_datv = !w_fifo_empty;
    assign Gc_capr_rdy   = (r_state == ST_IDLE);
    assign Gc_cap_cmpt   = r_cmpt;
    assign Gc_cap_drop   = r_drop;

endmodule

// File: tb/tb_tla_merge_pack.sv
// -----------------------------------------------------------------------------
// tb_tla_merge_pack
// Directed self-checking bench for tla_merge_pack (LANES=4, ADC0_0=14,
// DEPTH=16). Inputs change 1 time unit after the rising edge; outputs are
// checked at that point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_tla_merge_pack;

    localparam int ADC_W = 14;
    localparam int LN    = 4;
    localparam int DP    = 16;
    localparam int LW    = 32;

    logic                  Gc_clk125 = 1'b0;
    logic                  Gc_rst;
    logic [ADC_W-1:0]      Gc_adc_data;
    logic                  Gc_adc_of;
    logic                  Gc_adc_datv;
    logic                  Gc_cap_trig;
    logic [LW-1:0]         Gc_cap_plus;
    logic                  Gc_cap_abort;
    logic [LN*ADC_W-1:0]   Gc_merge_data;
    logic                  Gc_merge_of;
    logic                  Gc_merge_datv;
    logic                  Gc_merge_datr;
    logic                  Gc_capr_rdy;
    logic                  Gc_cap_cmpt;
    logic                  Gc_cap_drop;

    int errors = 0;
    int checks = 0;

    tla_merge_pack #(
        .ADC0_0 (ADC_W),
        .LANES  (LN),
        .DEPTH  (DP),
        .LDD0_0 (LW)
    ) dut (
        .Gc_clk125     (Gc_clk125),
        .Gc_rst        (Gc_rst),
        .Gc_adc_data   (Gc_adc_data),
        .Gc_adc_of     (Gc_adc_of),
        .Gc_adc_datv   (Gc_adc_datv),
        .Gc_cap_trig   (Gc_cap_trig),
        .Gc_cap_plus   (Gc_cap_plus),
        .Gc_cap_abort  (Gc_cap_abort),
        .Gc_merge_data (Gc_merge_data),
        .Gc_merge_of   (Gc_merge_of),
        .Gc_merge_datv (Gc_merge_datv),
        .Gc_merge_datr (Gc_merge_datr),
        .Gc_capr_rdy   (Gc_capr_rdy),
        .Gc_cap_cmpt   (Gc_cap_cmpt),
        .Gc_cap_drop   (Gc_cap_drop)
    );

    always #4 Gc_clk125 = ~Gc_clk125;

    // One line per accepted word.
    always @(posedge Gc_clk125) begin
        if (Gc_rst && Gc_merge_datv && Gc_merge_datr) begin
            $display("xfer data=%h of=%b", Gc_merge_data, Gc_merge_of);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LN*ADC_W-1:0] mk_word(input int a, input int b,
                                                   input int c, input int d);
        logic [ADC_W-1:0] l0, l1, l2, l3;
        l0 = a[ADC_W-1:0];
        l1 = b[ADC_W-1:0];
        l2 = c[ADC_W-1:0];
        l3 = d[ADC_W-1:0];
        return {l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge Gc_clk125);
        #1;
    endtask

    task automatic sample(input int v, input logic of);
        Gc_adc_data = v[ADC_W-1:0];
        Gc_adc_of   = of;
        Gc_adc_datv = 1'b1;
        step();
        Gc_adc_datv = 1'b0;
        Gc_adc_of   = 1'b0;
    endtask

    task automatic trigger(input int plus);
        Gc_cap_trig = 1'b1;
        Gc_cap_plus = plus;
        step();
        Gc_cap_trig = 1'b0;
    endtask

    task automatic test_reset();
        Gc_rst = 1'b0;
        repeat (3) @(posedge Gc_clk125);
        #1;
        checks++; if (Gc_merge_datv !== 1'b0) begin errors++; $display("FAIL reset_datv got=%b exp=0", Gc_merge_datv); end
        checks++; if (Gc_merge_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", Gc_merge_data); end
        checks++; if (Gc_merge_of !== 1'b0) begin errors++; $display("FAIL reset_of got=%b exp=0", Gc_merge_of); end
        checks++; if (Gc_capr_rdy !== 1'b1) begin errors++; $display("FAIL reset_capr_rdy got=%b exp=1", Gc_capr_rdy); end
        checks++; if (Gc_cap_cmpt !== 1'b0) begin errors++; $display("FAIL reset_cmpt got=%b exp=0", Gc_cap_cmpt); end
        checks++; if (Gc_cap_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", Gc_cap_drop); end
        Gc_rst = 1'b1;
        step();
        checks++; if (Gc_capr_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_capr_rdy got=%b exp=1", Gc_capr_rdy); end
    endtask

    task automatic test_basic();
        Gc_merge_datr = 1'b1;
        trigger(2);
        checks++; if (Gc_capr_rdy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", Gc_capr_rdy); end
        for (int i = 1; i <= 8; i++) begin
            sample(i, 1'b0);
            if (i == 3) begin
                checks++; if (Gc_merge_datv !== 1'b0) begin errors++; $display("FAIL basic_early_datv got=%b exp=0", Gc_merge_datv); end
            end
            if (i == 4) begin
                checks++; if (Gc_merge_datv !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b exp=1", Gc_merge_datv); end
                checks++; if (Gc_merge_data !== mk_word(1, 2, 3, 4)) begin errors++; $display("FAIL basic_word0 got=%h exp=%h", Gc_merge_data, mk_word(1, 2, 3, 4)); end
            end
            if (i == 5) begin
                checks++; if (Gc_merge_datv !== 1'b0) begin errors++; $display("FAIL basic_pop0 got=%b exp=0", Gc_merge_datv); end
            end
            if (i == 8) begin
                checks++; if (Gc_merge_data !== mk_word(5, 6, 7, 8)) begin errors++; $display("FAIL basic_word1 got=%h exp=%h", Gc_merge_data, mk_word(5, 6, 7, 8)); end
                checks++; if (Gc_cap_cmpt !== 1'b0) begin errors++; $display("FAIL basic_early_cmpt got=%b exp=0", Gc_cap_cmpt); end
            end
        end
        step();
        checks++; if (Gc_cap_cmpt !== 1'b1) begin errors++; $display("FAIL basic_cmpt got=%b exp=1", Gc_cap_cmpt); end
        checks++; if (Gc_capr_rdy !== 1'b1) begin errors++; $display("FAIL basic_capr_rdy got=%b exp=1", Gc_capr_rdy); end
        checks++; if (Gc_merge_datv !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", Gc_merge_datv); end
        step();
        checks++; if (Gc_cap_cmpt !== 1'b0) begin errors++; $display("FAIL basic_cmpt_width got=%b exp=0", Gc_cap_cmpt); end
    endtask

    task automatic test_overflow();
        Gc_merge_datr = 1'b0;
        trigger(18);
        for (int i = 0; i < 72; i++) begin
            sample(i + 1, 1'b0);
        end
        checks++; if (Gc_cap_drop !== 1'b1) begin errors++; $display("FAIL ovf_drop got=%b exp=1", Gc_cap_drop); end
        checks++; if (Gc_capr_rdy !== 1'b0) begin errors++; $display("FAIL ovf_busy got=%b exp=0", Gc_capr_rdy); end
        checks++; if (Gc_merge_data !== mk_word(1, 2, 3, 4)) begin errors++; $display("FAIL ovf_head got=%h exp=%h", Gc_merge_data, mk_word(1, 2, 3, 4)); end
        // Trigger while draining must be ignored (it would clear the drop flag).
        trigger(5);
        step();
        checks++; if (Gc_merge_data !== mk_word(1, 2, 3, 4)) begin errors++; $display("FAIL ovf_stable got=%h exp=%h", Gc_merge_data, mk_word(1, 2, 3, 4)); end
        checks++; if (Gc_cap_drop !== 1'b1) begin errors++; $display("FAIL ovf_trig_ignored got=%b exp=1", Gc_cap_drop); end
        Gc_merge_datr = 1'b1;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (Gc_merge_datv !== 1'b1 || Gc_merge_data !== mk_word(4*j+1, 4*j+2, 4*j+3, 4*j+4)) begin
                errors++;
                $display("FAIL ovf_drain_%0d got=%h v=%b exp=%h", j, Gc_merge_data, Gc_merge_datv, mk_word(4*j+1, 4*j+2, 4*j+3, 4*j+4));
            end
            step();
        end
        checks++; if (Gc_cap_cmpt !== 1'b1) begin errors++; $display("FAIL ovf_cmpt got=%b exp=1", Gc_cap_cmpt); end
        checks++; if (Gc_merge_datv !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", Gc_merge_datv); end
        checks++; if (Gc_capr_rdy !== 1'b1) begin errors++; $display("FAIL ovf_capr_rdy got=%b exp=1", Gc_capr_rdy); end
        step();
    endtask

    task automatic test_overrange();
        Gc_merge_datr = 1'b1;
        trigger(2);
        checks++; if (Gc_cap_drop !== 1'b0) begin errors++; $display("FAIL of_drop_cleared got=%b exp=0", Gc_cap_drop); end
        for (int i = 11; i <= 18; i++) begin
            sample(i, (i == 13));
            if (i == 14) begin
                checks++; if (Gc_merge_of !== 1'b1) begin errors++; $display("FAIL of_word0 got=%b exp=1", Gc_merge_of); end
                checks++; if (Gc_merge_data !== mk_word(11, 12, 13, 14)) begin errors++; $display("FAIL of_data0 got=%h exp=%h", Gc_merge_data, mk_word(11, 12, 13, 14)); end
            end
            if (i == 18) begin
                checks++; if (Gc_merge_of !== 1'b0 || Gc_merge_datv !== 1'b1) begin errors++; $display("FAIL of_word1 got=%b v=%b exp=0", Gc_merge_of, Gc_merge_datv); end
            end
        end
        step();
        checks++; if (Gc_cap_cmpt !== 1'b1) begin errors++; $display("FAIL of_cmpt got=%b exp=1", Gc_cap_cmpt); end
        step();
    endtask

    task automatic test_abort();
        int pulses;
        Gc_merge_datr = 1'b0;
        trigger(4);
        for (int i = 1; i <= 6; i++) begin
            sample(i, 1'b0);
        end
        checks++; if (Gc_merge_datv !== 1'b1) begin errors++; $display("FAIL abort_queued got=%b exp=1", Gc_merge_datv); end
        Gc_cap_abort = 1'b1;
        step();
        Gc_cap_abort = 1'b0;
        checks++; if (Gc_merge_datv !== 1'b0) begin errors++; $display("FAIL abort_datv got=%b exp=0", Gc_merge_datv); end
        checks++; if (Gc_capr_rdy !== 1'b1) begin errors++; $display("FAIL abort_capr_rdy got=%b exp=1", Gc_capr_rdy); end
        pulses = (Gc_cap_cmpt === 1'b1) ? 1 : 0;
        repeat (3) begin
            step();
            if (Gc_cap_cmpt === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_cmpt got=%0d exp=0", pulses); end
        // Samples while IDLE are ignored: a full word's worth must not queue.
        for (int i = 1; i <= 4; i++) begin
            sample(100 + i, 1'b1);
        end
        checks++; if (Gc_merge_datv !== 1'b0) begin errors++; $display("FAIL idle_samples got=%b exp=0", Gc_merge_datv); end
        // The discarded partial word must not shift the lanes of the next capture.
        Gc_merge_datr = 1'b1;
        trigger(1);
        for (int i = 21; i <= 24; i++) begin
            sample(i, 1'b0);
        end
        checks++; if (Gc_merge_data !== mk_word(21, 22, 23, 24)) begin errors++; $display("FAIL abort_next_word got=%h exp=%h", Gc_merge_data, mk_word(21, 22, 23, 24)); end
        step();
        checks++; if (Gc_cap_cmpt !== 1'b1) begin errors++; $display("FAIL abort_next_cmpt got=%b exp=1", Gc_cap_cmpt); end
        step();
    endtask

    task automatic test_zero_len();
        int seen;
        trigger(0);
        checks++; if (Gc_cap_cmpt !== 1'b1) begin errors++; $display("FAIL zero_cmpt got=%b exp=1", Gc_cap_cmpt); end
        checks++; if (Gc_capr_rdy !== 1'b1) begin errors++; $display("FAIL zero_capr_rdy got=%b exp=1", Gc_capr_rdy); end
        step();
        checks++; if (Gc_cap_cmpt !== 1'b0) begin errors++; $display("FAIL zero_cmpt_width got=%b exp=0", Gc_cap_cmpt); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            sample(200 + i, 1'b0);
            if (Gc_merge_datv !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL zero_datv got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        Gc_merge_datr = 1'b0;
        trigger(3);
        for (int i = 1; i <= 5; i++) begin
            sample(i, 1'b1);
        end
        checks++; if (Gc_merge_datv !== 1'b1) begin errors++; $display("FAIL rstmid_queued got=%b exp=1", Gc_merge_datv); end
        Gc_rst = 1'b0;
        #1;
        checks++; if (Gc_merge_datv !== 1'b0) begin errors++; $display("FAIL rstmid_datv got=%b exp=0", Gc_merge_datv); end
        checks++; if (Gc_merge_data !== '0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", Gc_merge_data); end
        checks++; if (Gc_merge_of !== 1'b0) begin errors++; $display("FAIL rstmid_of got=%b exp=0", Gc_merge_of); end
        checks++; if (Gc_capr_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_capr_rdy got=%b exp=1", Gc_capr_rdy); end
        checks++; if (Gc_cap_cmpt !== 1'b0 || Gc_cap_drop !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b%b exp=00", Gc_cap_cmpt, Gc_cap_drop); end
        step();
        Gc_rst = 1'b1;
        pulses = 0;
        repeat (3) begin
            step();
            if (Gc_cap_cmpt === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_cmpt got=%0d exp=0", pulses); end
        Gc_merge_datr = 1'b1;
        trigger(1);
        for (int i = 41; i <= 44; i++) begin
            sample(i, 1'b0);
        end
        checks++; if (Gc_merge_datv !== 1'b1 || Gc_merge_data !== mk_word(41, 42, 43, 44)) begin errors++; $display("FAIL rstmid_word got=%h v=%b exp=%h", Gc_merge_data, Gc_merge_datv, mk_word(41, 42, 43, 44)); end
        step();
        checks++; if (Gc_cap_cmpt !== 1'b1) begin errors++; $display("FAIL rstmid_cmpt got=%b exp=1", Gc_cap_cmpt); end
        checks++; if (Gc_capr_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_capr_rdy_end got=%b exp=1", Gc_capr_rdy); end
    endtask

    initial begin
        Gc_rst        = 1'b0;
        Gc_adc_data   = '0;
        Gc_adc_of     = 1'b0;
        Gc_adc_datv   = 1'b0;
        Gc_cap_trig   = 1'b0;
        Gc_cap_plus   = '0;
        Gc_cap_abort  = 1'b0;
        Gc_merge_datr = 1'b0;

        test_reset();
        test_basic();
        test_overflow();
        test_overrange();
        test_abort();
        test_zero_len();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tla_merge_pack.md
TLA_MERGE_PACK -- requirements
Module: tla_merge_pack

Interface
REQ-001 Parameter ADC0_0, default 14: ADC sample width in bits.
REQ-002 Parameter LANES, default 4: samples per merge word; legal range 2..16.
REQ-003 Parameter DEPTH, default 16: output FIFO depth in words; power of two, 4..256.
REQ-004 Parameter LDD0_0, default 32: width of the capture-length field.
REQ-005 Gc_clk125  in  1  single clock; all logic is on its rising edge.
REQ-006 Gc_rst  in  1  asynchronous, active-low reset.
REQ-007 Gc_adc_data  in  ADC0_0  sample data.
REQ-008 Gc_adc_of  in  1  overrange flag of the same sample.
REQ-009 Gc_adc_datv  in  1  sample valid, one sample per cycle at most.
REQ-010 Gc_cap_trig  in  1  capture start, one-cycle pulse.
REQ-011 Gc_cap_plus  in  LDD0_0  number of merge words to capture; sampled with Gc_cap_trig.
REQ-012 Gc_cap_abort  in  1  cancels the capture, one-cycle pulse.
REQ-013 Gc_merge_data  out  LANES*ADC0_0  packed word; lane 0 occupies the LSBs.
REQ-014 Gc_merge_of  out  1  OR of the overrange flags of all lanes in the presented word.
REQ-015 Gc_merge_datv  out  1  word valid.
REQ-016 Gc_merge_datr  in  1  consumer ready.
REQ-017 Gc_capr_rdy  out  1  high while IDLE.
REQ-018 Gc_cap_cmpt  out  1  one-cycle pulse when the capture finishes.
REQ-019 Gc_cap_drop  out  1  sticky flag: at least one word was lost to a full FIFO.

Function
REQ-020 The FSM SHALL have three states: IDLE, PACK and DRAIN.
REQ-021 In IDLE, Gc_cap_trig with Gc_cap_plus!=0 SHALL:
- load the word counter from Gc_cap_plus;
- clear Gc_cap_drop;
- clear the lane index;
- enter PACK on the next cycle.
REQ-022 In IDLE, Gc_cap_trig with Gc_cap_plus==0 SHALL pulse Gc_cap_cmpt on the next cycle and stay in IDLE.
REQ-023 Gc_cap_trig outside IDLE SHALL be ignored.
REQ-024 Samples with Gc_adc_datv=1 are used only in PACK; each goes into the current lane, then the lane index increments.
REQ-025 Filling lane LANES-1 SHALL:
- form one word and push it to the FIFO;
- reset the lane index to 0;
- decrement the word counter.
REQ-026 When a word completes and the FIFO is full with no pop in the same cycle, the word SHALL be dropped and Gc_cap_drop set; the word counter still decrements.
REQ-027 With the FIFO full, a pop and a push in the same cycle SHALL both succeed.
REQ-028 When the word counter reaches 0, the FSM SHALL go from PACK to DRAIN.
REQ-029 In DRAIN, the cycle the FIFO becomes empty SHALL pulse Gc_cap_cmpt for one cycle and return to IDLE.
REQ-030 The FIFO is show-ahead. A word is accepted when Gc_merge_datv and Gc_merge_datr are both 1.
REQ-031 Gc_merge_data and Gc_merge_of SHALL stay stable while Gc_merge_datv=1 and Gc_merge_datr=0.
REQ-032 Latency: Gc_merge_datv SHALL rise one cycle after the cycle that samples lane LANES-1, when the FIFO was empty.
REQ-033 Gc_cap_abort in any state SHALL, on the next cycle:
- return the FSM to IDLE;
- flush the FIFO;
- discard the partial word;
- deassert Gc_merge_datv;
- produce no Gc_cap_cmpt pulse.
REQ-034 Gc_cap_abort SHALL take priority over a simultaneous trigger, push or pop.
REQ-035 Samples arriving outside PACK SHALL be ignored.

Reset
REQ-036 While Gc_rst=0 the block SHALL hold these values:
- FSM=IDLE, FIFO empty, lane index 0, word counter 0;
- Gc_merge_datv=0, Gc_merge_data=0, Gc_merge_of=0;
- Gc_capr_rdy=1, Gc_cap_cmpt=0, Gc_cap_drop=0.
REQ-037 Reset asserted mid-capture SHALL abandon the capture with no Gc_cap_cmpt pulse.

Structure
REQ-038 The FSM state enum and the default parameter values SHALL live in the shared package tla_pkg.
REQ-039 The FIFO SHALL be a sub-module, tla_sync_fifo, parametrised by width and depth, with full and empty outputs.

Verification
REQ-040 The bench SHALL cover these directed scenarios (LANES=4, ADC0_0=14, DEPTH=16):
- Trig, plus=2; samples 1..8 back-to-back; datr=1 -> word0 lanes = 1,2,3,4 (lane 0 = 1), word1 lanes = 5,6,7,8; one cmpt pulse after word1 is accepted; capr_rdy back to 1.
- Trig, plus=18; datr=0 until the counter reaches 0 -> 16 words stored, drop=1; the 16 words drain in order, then cmpt.
- of=1 on sample 3 only, plus=2 -> merge_of=1 on word0, 0 on word1.
- Abort after 6 samples with 1 word queued -> datv=0 and capr_rdy=1 on the next cycle; no cmpt.
- Trig, plus=0 -> cmpt one cycle later; datv never rises.
- Gc_rst low mid-PACK -> every output takes its reset value immediately; a new trig, plus=1 then works normally.
